// File: rtl/muldiv_ctrl_if.sv
// Divider-side bundle between the HI/LO controller and the iterative divider.
// master: controller (start/abandon/operands out, ready/result in); slave: divider.
interface muldiv_ctrl_if;
    logic        div_start;
    logic        div_abandon;
    logic        div_signed;
    logic [31:0] div_opr1;
    logic [31:0] div_opr2;
    logic        div_ready;
    logic [63:0] div_res;

    modport master (
        output div_start,
        output div_abandon,
        output div_signed,
        output div_opr1,
        output div_opr2,
        input  div_ready,
        input  div_res
    );

    modport slave (
        input  div_start,
        input  div_abandon,
        input  div_signed,
        input  div_opr1,
        input  div_opr2,
        output div_ready,
        output div_res
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: owns HI/LO, sequences an external divider,
// runs a one-cycle multiply, and raises a combinational pipeline stall.
// Ports: clk, rst (async, active-high), op/opr1/opr2/flush from the pipeline,
// stall/hi/lo to the pipeline, div (master side of muldiv_ctrl_if) to the divider.
module muldiv_ctrl (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          op,
    input  logic [31:0]         opr1,
    input  logic [31:0]         opr2,
    input  logic                flush,
    output logic                stall,
    output logic [31:0]         hi,
    output logic [31:0]         lo,
    muldiv_ctrl_if.master       div
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        DIV_WAIT,
        DIV_DONE,
        MUL_WB
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] prod_q, prod_d;
    logic        sgn_q, sgn_d;

    logic        is_div;
    logic        is_mul;
    logic        start;
    logic        abandon;
    logic        ext1;
    logic        ext2;
    logic [63:0] mul_a;
    logic [63:0] mul_b;

    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);

    // Low 64 bits of a product are sign-agnostic, so extend to 64 and
    // multiply unsigned: that equals the 33x33 signed/unsigned result.
    assign ext1  = (op == OP_MULT) && opr1[31];
    assign ext2  = (op == OP_MULT) && opr2[31];
    assign mul_a = {{32{ext1}}, opr1};
    assign mul_b = {{32{ext2}}, opr2};

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        sgn_d   = sgn_q;
        stall   = 1'b0;
        start   = 1'b0;
        abandon = 1'b0;
        if (flush) begin
            abandon = 1'b1;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DIV_DONE: begin
                    // DIV_DONE drops div_start for one cycle so the divider
                    // frees up; a new divide waits there and starts from IDLE.
                    if (state_q == DIV_DONE) state_d = IDLE;
                    if (is_div) begin
                        stall = 1'b1;
                        if (state_q == IDLE) begin
                            start   = 1'b1;
                            sgn_d   = (op == OP_DIV);
                            state_d = DIV_WAIT;
                        end
                    end else if (is_mul) begin
                        stall   = 1'b1;
                        prod_d  = mul_a * mul_b;
                        state_d = MUL_WB;
                    end else if (op == OP_MTHI) begin
                        hi_d = opr1;
                    end else if (op == OP_MTLO) begin
                        lo_d = opr1;
                    end
                end
                DIV_WAIT: begin
                    start = 1'b1;
                    if (div.div_ready) begin
                        hi_d    = div.div_res[63:32];
                        lo_d    = div.div_res[31:0];
                        state_d = DIV_DONE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                MUL_WB: begin
                    hi_d    = prod_q[63:32];
                    lo_d    = prod_q[31:0];
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        // Outputs are quiet for the whole time reset is held.
        if (rst) begin
            stall   = 1'b0;
            start   = 1'b0;
            abandon = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            prod_q  <= 64'd0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            sgn_q   <= sgn_d;
        end
    end

    assign hi              = hi_q;
    assign lo              = lo_q;
    assign div.div_start   = start;
    assign div.div_abandon = abandon;
    assign div.div_signed  = start & sgn_d;
    assign div.div_opr1    = start ? opr1 : 32'd0;
    assign div.div_opr2    = start ? opr2 : 32'd0;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: behavioural divider with fixed latency,
// scoreboard of expected HI/LO values popped at each writeback.
module tb_muldiv_ctrl;
    localparam int LAT = 34;
    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] MULT  = 3'd1;
    localparam logic [2:0] MULTU = 3'd2;
    localparam logic [2:0] DIV   = 3'd3;
    localparam logic [2:0] DIVU  = 3'd4;
    localparam logic [2:0] MTHI  = 3'd5;
    localparam logic [2:0] MTLO  = 3'd6;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [2:0]  op    = 3'd0;
    logic [31:0] opr1  = 32'd0;
    logic [31:0] opr2  = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_v;

    muldiv_ctrl_if dif ();

    muldiv_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .op    (op),
        .opr1  (opr1),
        .opr2  (opr2),
        .flush (flush),
        .stall (stall),
        .hi    (hi),
        .lo    (lo),
        .div   (dif)
    );

    always #5 clk = ~clk;

    // Divider stand-in: counts cycles of continuous div_start, ready at LAT.
    int unsigned dcnt;
    logic [31:0] dq;
    logic [31:0] dr;

    always @(posedge clk or posedge rst) begin
        if (rst) dcnt <= 0;
        else if (dif.div_abandon || !dif.div_start) dcnt <= 0;
        else dcnt <= dcnt + 1;
    end

    always @* begin
        dq = 32'd0;
        dr = 32'd0;
        if (dif.div_opr2 != 32'd0) begin
            if (dif.div_signed) begin
                dq = $signed(dif.div_opr1) / $signed(dif.div_opr2);
                dr = $signed(dif.div_opr1) % $signed(dif.div_opr2);
            end else begin
                dq = dif.div_opr1 / dif.div_opr2;
                dr = dif.div_opr1 % dif.div_opr2;
            end
        end
    end

    assign dif.div_ready = dif.div_start && (dcnt == LAT);
    assign dif.div_res   = {dr, dq};

    // Drive point is posedge+1, sample point is posedge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        op   = o;
        opr1 = a;
        opr2 = b;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 200) begin
            n++;
            tick();
            #1;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout op=%0d stall still high after %0d cycles", o, n);
        end
    endtask

    task automatic pop_check(input string name);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty got=%h", name, {hi, lo});
        end else begin
            exp_v = sb.pop_front();
            if ({hi, lo} !== exp_v) begin
                errors++;
                $display("FAIL %s got hi:lo=%h want=%h", name, {hi, lo}, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        op   = DIV;
        opr1 = 32'd5;
        opr2 = 32'd3;
        tick();
        tick();
        #1;
        checks++;
        if ({stall, dif.div_start, dif.div_abandon} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=000",
                     {stall, dif.div_start, dif.div_abandon});
        end
        checks++;
        if ({hi, lo} !== 64'd0) begin
            errors++;
            $display("FAIL reset_hilo got=%h want=0", {hi, lo});
        end
        checks++;
        if (dif.div_opr1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_opr1 got=%h want=0", dif.div_opr1);
        end
        tick();
        op  = NOP;
        rst = 1'b0;
    endtask

    task automatic test_div();
        int n;
        sb.push_back({32'h00000001, 32'hFFFFFFFD});
        op   = DIV;
        opr1 = 32'd7;
        opr2 = 32'hFFFFFFFE;
        #1;
        checks++;
        if ({dif.div_start, dif.div_signed} !== 2'b11 ||
            dif.div_opr1 !== 32'd7 || dif.div_opr2 !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL div_issue got start=%b sgn=%b o1=%h o2=%h want 1 1 7 fffffffe",
                     dif.div_start, dif.div_signed, dif.div_opr1, dif.div_opr2);
        end
        #1;
        run_op(DIV, 32'd7, 32'hFFFFFFFE, n);
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL div_stall_cycles got=%0d want=%0d", n, LAT);
        end
        checks++;
        if ({dif.div_start, dif.div_signed} !== 2'b11) begin
            errors++;
            $display("FAIL div_ready_cycle got start/sgn=%b want=11",
                     {dif.div_start, dif.div_signed});
        end
        tick();
        op = NOP;
        #1;
        checks++;
        if ({dif.div_start, stall} !== 2'b00) begin
            errors++;
            $display("FAIL div_done got start/stall=%b want=00", {dif.div_start, stall});
        end
        pop_check("div_signed_result");
        tick();
    endtask

    task automatic test_mult();
        int n;
        logic [2:0]  ops[4] = '{MULTU, MULT, MULT, MULTU};
        logic [31:0] as[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'd3, 32'd3};
        logic [63:0] rs[4]  = '{64'h00000001_FFFFFFFE, 64'hFFFFFFFF_FFFFFFFE,
                                64'hFFFFFFFE_80000000, 64'h00000001_80000000};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(rs[i]);
            run_op(ops[i], as[i], bs[i], n);
            checks++;
            if (n != 1) begin
                errors++;
                $display("FAIL mul_stall_cycles[%0d] got=%0d want=1", i, n);
            end
            tick();
            op = NOP;
            #1;
            pop_check("mul_result");
            tick();
        end
    endtask

    task automatic test_mt();
        int n;
        sb.push_back({32'h12345678, 32'h9ABCDEF0});
        run_op(MTHI, 32'h12345678, 32'd0, n);
        tick();
        op   = MTLO;
        opr1 = 32'h9ABCDEF0;
        #1;
        checks++;
        if (n != 0 || stall !== 1'b0 || hi !== 32'h12345678) begin
            errors++;
            $display("FAIL mthi got n=%0d stall=%b hi=%h want 0 0 12345678", n, stall, hi);
        end
        tick();
        op = NOP;
        #1;
        pop_check("mt_result");
        tick();
    endtask

    task automatic test_flush();
        op   = DIVU;
        opr1 = 32'd1000;
        opr2 = 32'd3;
        #1;
        repeat (10) tick();
        #1;
        checks++;
        if ({stall, dif.div_start} !== 2'b11) begin
            errors++;
            $display("FAIL flush_pre got stall/start=%b want=11", {stall, dif.div_start});
        end
        flush = 1'b1;
        #1;
        checks++;
        if ({dif.div_abandon, stall, dif.div_start} !== 3'b100 || dif.div_opr1 !== 32'd0) begin
            errors++;
            $display("FAIL flush_cycle got aban/stall/start=%b opr1=%h want=100 0",
                     {dif.div_abandon, stall, dif.div_start}, dif.div_opr1);
        end
        tick();
        flush = 1'b0;
        op    = NOP;
        #1;
        checks++;
        if ({dif.div_abandon, stall, dif.div_start} !== 3'b000) begin
            errors++;
            $display("FAIL flush_after got aban/stall/start=%b want=000",
                     {dif.div_abandon, stall, dif.div_start});
        end
        repeat (LAT + 6) tick();
        #1;
        checks++;
        if ({hi, lo} !== {32'h12345678, 32'h9ABCDEF0}) begin
            errors++;
            $display("FAIL flush_hilo got=%h want=123456789abcdef0", {hi, lo});
        end
        tick();
    endtask

    task automatic test_flush_mul();
        op   = MULTU;
        opr1 = 32'd5;
        opr2 = 32'd7;
        tick();
        #1;
        flush = 1'b1;
        #1;
        checks++;
        if ({dif.div_abandon, stall} !== 2'b10) begin
            errors++;
            $display("FAIL flush_mul_cycle got aban/stall=%b want=10", {dif.div_abandon, stall});
        end
        tick();
        flush = 1'b0;
        op    = NOP;
        #1;
        checks++;
        if ({hi, lo} !== {32'h12345678, 32'h9ABCDEF0}) begin
            errors++;
            $display("FAIL flush_mul_hilo got=%h want=123456789abcdef0", {hi, lo});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        sb.push_back({32'd2, 32'd14});
        sb.push_back({32'd0, 32'd0});
        run_op(DIVU, 32'd100, 32'd7, n);
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL b2b_first_stalls got=%0d want=%0d", n, LAT);
        end
        tick();
        op   = DIVU;
        opr1 = 32'd9;
        opr2 = 32'd0;
        #1;
        checks++;
        if ({stall, dif.div_start} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_done got stall/start=%b want=10", {stall, dif.div_start});
        end
        pop_check("b2b_first_result");
        tick();
        #1;
        checks++;
        if ({stall, dif.div_start, dif.div_signed} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_restart got stall/start/sgn=%b want=110",
                     {stall, dif.div_start, dif.div_signed});
        end
        n = 1;
        while (stall === 1'b1 && n < 200) begin
            n++;
            tick();
            #1;
        end
        checks++;
        if (n != LAT + 1) begin
            errors++;
            $display("FAIL b2b_second_stalls got=%0d want=%0d", n, LAT + 1);
        end
        tick();
        op = NOP;
        #1;
        pop_check("b2b_divzero_result");
        tick();
    endtask

    task automatic test_rst_mid_div();
        int n;
        run_op(MTHI, 32'hAAAA5555, 32'd0, n);
        tick();
        op   = DIVU;
        opr1 = 32'd50;
        opr2 = 32'd5;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({stall, dif.div_start, dif.div_abandon} !== 3'b000 || {hi, lo} !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid_div got ctrl=%b hilo=%h want 000 0",
                     {stall, dif.div_start, dif.div_abandon}, {hi, lo});
        end
        tick();
        rst = 1'b0;
        op  = NOP;
        repeat (LAT + 10) tick();
        #1;
        checks++;
        if ({hi, lo} !== 64'd0 || dif.div_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_release got hilo=%h start=%b want 0 0", {hi, lo}, dif.div_start);
        end
    endtask

    initial begin
        test_reset();
        test_div();
        test_mult();
        test_mt();
        test_flush();
        test_flush_mul();
        test_back_to_back();
        test_rst_mid_div();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port op, input, 3, operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NOP.
REQ-004 SHALL have ports opr1 and opr2, input, 32 each; rs and rt operand values, held stable by the pipeline while stall=1.
REQ-005 SHALL have port flush, input, 1; pipeline flush that kills the in-flight operation.
REQ-006 SHALL have port stall, output, 1; combinational pipeline stall request.
REQ-007 SHALL have ports hi and lo, output, 32 each; architectural HI/LO registers.
REQ-008 SHALL have divider-side ports div_start, div_abandon and div_signed, output, 1 each; and div_opr1 and div_opr2, output, 32 each.
REQ-009 SHALL have divider-side ports div_ready, input, 1; and div_res, input, 64, where [63:32] is the remainder and [31:0] the quotient.

Function
REQ-010 SHALL implement FSM states IDLE, DIV_WAIT, DIV_DONE and MUL_WB.
REQ-011 SHALL, in IDLE with op=DIV or DIVU:
- assert div_start and stall combinationally;
- drive div_signed=1 for DIV and 0 for DIVU;
- drive div_opr1=opr1 and div_opr2=opr2;
- next state DIV_WAIT.
REQ-012 SHALL, in DIV_WAIT:
- hold div_start=1 and the same div_signed/div_opr values;
- hold stall=1 while div_ready=0.
REQ-013 SHALL, in DIV_WAIT with div_ready=1 in the same cycle:
- drive stall=0;
- on that edge load hi<=div_res[63:32] and lo<=div_res[31:0];
- next state DIV_DONE.
REQ-014 SHALL hold div_start=0 for exactly one cycle in DIV_DONE so the divider returns to free, and then go to IDLE.
- A DIV/DIVU presented in DIV_DONE SHALL see stall=1 and start from IDLE in the next cycle.
- MULT/MULTU/MTHI/MTLO presented in DIV_DONE SHALL be handled as in IDLE.
REQ-015 SHALL, in IDLE with op=MULT or MULTU:
- assert stall for one cycle;
- register the 64-bit product (MULT: sign-extended 33x33 signed; MULTU: zero-extended);
- next state MUL_WB.
REQ-016 SHALL, in MUL_WB:
- drive stall=0;
- on that edge load hi<=product[63:32] and lo<=product[31:0];
- next state IDLE.
REQ-017 SHALL handle MTHI/MTLO in IDLE or DIV_DONE with no stall: hi<=opr1 (MTHI) or lo<=opr1 (MTLO) on the next edge.
REQ-018 SHALL keep hi/lo unchanged in every cycle not named in REQ-013, REQ-016 and REQ-017.
REQ-019 SHALL store a divide-by-zero result exactly as returned by the divider on div_res; no special casing.
REQ-020 SHALL handle flush=1, which has priority over all other inputs:
- div_abandon=1 combinationally in that cycle;
- div_start=0 and stall=0;
- next state IDLE;
- no HI/LO write that cycle, including when div_ready=1 or the state is MUL_WB.
REQ-021 SHALL drive div_abandon=0 whenever flush=0.
REQ-022 SHALL drive div_opr1 and div_opr2 to 0 when div_start=0.

Reset
REQ-023 SHALL, while rst=1: set state=IDLE, hi=0, lo=0 and the product register to 0; drive stall=0, div_start=0 and div_abandon=0.
REQ-024 SHALL, on reset mid-division, discard the pending result and not write HI/LO after rst falls; divider recovery relies on its own rst.

Verification
REQ-025 SHALL be verified with: DIV opr1=7, opr2=0xFFFFFFFE with a divider model returning after 34 cycles -> stall high until the ready cycle, then hi=0x00000001, lo=0xFFFFFFFD, and div_start low for exactly one cycle in DIV_DONE.
REQ-026 SHALL be verified with: MULTU 0xFFFFFFFF x 0x00000002 -> stall for 1 cycle, then hi=0x00000001, lo=0xFFFFFFFE; and MULT 0xFFFFFFFF x 2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-027 SHALL be verified with: flush asserted in the 10th DIV_WAIT cycle -> div_abandon=1 for 1 cycle, stall=0, state IDLE, hi/lo unchanged.
REQ-028 SHALL be verified with: back-to-back DIVU 100/7 then DIVU 9/0 -> first result hi=2, lo=14; one DIV_DONE cycle with stall=1; second result hi=0, lo=0.
REQ-029 SHALL be verified with: MTHI 0x12345678 then MTLO 0x9ABCDEF0 in consecutive cycles -> no stall, hi=0x12345678, lo=0x9ABCDEF0.
REQ-030 SHALL be verified with: rst asserted mid-division -> all outputs at reset values immediately; no HI/LO write after release.
